// File: rtl/display_scan.sv
// Six-digit multiplexed common-anode 7-segment scanner with per-frame input snapshot and dead time.
// Optional leading-zero blanking of the hours-tens digit in 12h mode: define DISPLAY_LZB_EN.
module display_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] hh_t,
   input  logic [3:0] hh_u,
   input  logic [3:0] mm_t,
   input  logic [3:0] mm_u,
   input  logic [3:0] ss_t,
   input  logic [3:0] ss_u,
   input  logic       flag_pm,
   input  logic       flag_24h,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_start
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0][3:0] snap_q, snap_d;
   logic            pm_q, pm_d;
   logic            h24_q, h24_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [5:0]      an_q, an_d;
   logic            frame_q, frame_d;
   logic [5:0][3:0] live;
   logic [6:0]      glyph [8];
   logic            wrap, blank;

   assign live = {ss_u, ss_t, mm_u, mm_t, hh_u, hh_t};

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         4'hF:    decode = 7'h7F;
         default: decode = 7'b0111111;
      endcase
   endfunction

   // Per-slot glyphs decoded from the snapshot; entries 6 and 7 are unreachable padding.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_glyph
         if (gi == 0) begin : g_hours_tens
`ifdef DISPLAY_LZB_EN
            assign glyph[gi] = (snap_q[0] == 4'd0 && !h24_q) ? 7'h7F : decode(snap_q[0]);
`else
            assign glyph[gi] = decode(snap_q[0]);
`endif
         end else if (gi < 6) begin : g_digit
            assign glyph[gi] = decode(snap_q[gi]);
         end else begin : g_pad
            assign glyph[gi] = 7'h7F;
         end
      end
   endgenerate

   always_comb begin
      wrap    = (cnt_q == CNT_LAST);
      blank   = (cnt_q < CNT_BLANK);
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      if (wrap) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      frame_d = wrap && (idx_q == 3'd5);
      snap_d  = snap_q;
      pm_d    = pm_q;
      h24_d   = h24_q;
      if (frame_d) begin
         snap_d = live;
         pm_d   = flag_pm;
         h24_d  = flag_24h;
      end
      an_d  = 6'b111111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (!blank) begin
         an_d  = ~(6'b000001 << idx_q);
         seg_d = glyph[idx_q];
         dp_d  = !(((idx_q == 3'd1) && pm_q && !h24_q) || ((idx_q == 3'd5) && h24_q));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         snap_q  <= {6{4'hF}};
         pm_q    <= 1'b0;
         h24_q   <= 1'b0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= 6'b111111;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         pm_q    <= pm_d;
         h24_q   <= h24_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign an          = an_q;
   assign frame_start = frame_q;
endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: expected slot contents are queued when inputs are driven and compared per captured frame.
module tb_display_scan;
   localparam int SD = 8;
   localparam int BC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] hh_t = 4'hF, hh_u = 4'hF, mm_t = 4'hF, mm_u = 4'hF, ss_t = 4'hF, ss_u = 4'hF;
   logic       flag_pm = 1'b0, flag_24h = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       frame_start;

   int total = 0;
   int bad = 0;

   typedef struct {logic [5:0] an; logic [6:0] seg; logic dp;} exp_t;
   typedef struct {logic [5:0] an; logic [6:0] seg; logic dp; int nlow; bit clean;} obs_t;
   exp_t exp_q[$];
   obs_t obs_q[$];

   display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst(rst),
      .hh_t(hh_t), .hh_u(hh_u), .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
      .flag_pm(flag_pm), .flag_24h(flag_24h),
      .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_glyph(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
         4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
         4'd8: return 7'h00;  4'd9: return 7'h10;  4'hF: return 7'h7F;
         default: return 7'h3F;
      endcase
   endfunction

   // d packs digits hours-tens first in the top nibble: {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}
   task automatic drive_frame(input logic [23:0] d, input logic pm, input logic h24);
      exp_t e;
      {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u} = d;
      flag_pm = pm;
      flag_24h = h24;
      for (int k = 0; k < 6; k++) begin
         logic [3:0] dig;
         dig = d[20 - 4*k +: 4];
         e.an = ~(6'b000001 << k);
         e.seg = ref_glyph(dig);
`ifdef DISPLAY_LZB_EN
         if (k == 0 && dig == 4'd0 && !h24) e.seg = 7'h7F;
`endif
         e.dp = !((k == 1 && pm && !h24) || (k == 5 && h24));
         exp_q.push_back(e);
      end
   endtask

   task automatic capture_frame();
      int w;
      obs_t o;
      w = 0;
      while (frame_start !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (frame_start !== 1'b1) begin
         total++; bad++;
         $display("FAIL frame_timeout frame_start got=%b want=1", frame_start);
      end
      for (int s = 0; s < 6; s++) begin
         o = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1, nlow: 0, clean: 1'b1};
         for (int c = 0; c < SD; c++) begin
            @(negedge clk);
            if ($countones(~an) > 1) o.clean = 1'b0;
            if (c < BC) begin
               if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) o.clean = 1'b0;
            end else begin
               if (an !== 6'h3F) o.nlow++;
               if (c == BC) begin
                  o.an = an; o.seg = seg; o.dp = dp;
               end else if (an !== o.an || seg !== o.seg || dp !== o.dp) begin
                  o.clean = 1'b0;
               end
            end
         end
         obs_q.push_back(o);
      end
   endtask

   task automatic test_reset();
      int n;
      repeat (3) @(negedge clk);
      total++; if (an !== 6'h3F) begin bad++; $display("FAIL reset_an got=%b want=111111", an); end
      total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=7f", seg); end
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
      rst = 1'b0;
      n = 0;
      while (frame_start !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++; if (n != 6*SD) begin bad++; $display("FAIL reset_first_fs cycles got=%0d want=%0d", n, 6*SD); end
      $display("test_reset: first frame_start after %0d cycles", n);
   endtask

   task automatic test_decode();
      exp_t e; obs_t o;
      drive_frame(24'h123456, 1'b0, 1'b1);
      @(negedge clk);
      capture_frame();
      for (int s = 0; s < 6; s++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o.an !== e.an) begin bad++; $display("FAIL decode_an slot%0d got=%b want=%b", s, o.an, e.an); end
         total++; if (o.seg !== e.seg) begin bad++; $display("FAIL decode_seg slot%0d got=%h want=%h", s, o.seg, e.seg); end
         total++; if (o.dp !== e.dp) begin bad++; $display("FAIL decode_dp slot%0d got=%b want=%b", s, o.dp, e.dp); end
         total++; if (o.nlow != SD-BC) begin bad++; $display("FAIL decode_low slot%0d got=%0d want=%0d", s, o.nlow, SD-BC); end
         total++; if (!o.clean) begin bad++; $display("FAIL decode_clean slot%0d got=0 want=1", s); end
         $display("test_decode: slot%0d an=%b seg=%h dp=%b low=%0d", s, o.an, o.seg, o.dp, o.nlow);
      end
   endtask

   task automatic test_reset_async();
      int w, n;
      w = 0;
      while ((an === 6'h3F) && w < 100) begin
         @(negedge clk);
         w++;
      end
      #2 rst = 1'b1;
      #1;
      total++; if (an !== 6'h3F) begin bad++; $display("FAIL async_an got=%b want=111111", an); end
      total++; if (seg !== 7'h7F) begin bad++; $display("FAIL async_seg got=%h want=7f", seg); end
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL async_dp got=%b want=1", dp); end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (frame_start !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++; if (n != 6*SD) begin bad++; $display("FAIL async_restart cycles got=%0d want=%0d", n, 6*SD); end
      $display("test_reset_async: outputs off, restart frame_start after %0d cycles", n);
   endtask

   task automatic test_blank_dash();
      exp_t e; obs_t o;
      drive_frame(24'h123FB0, 1'b0, 1'b1);
      @(negedge clk);
      capture_frame();
      for (int s = 0; s < 6; s++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o.seg !== e.seg) begin bad++; $display("FAIL blank_seg slot%0d got=%h want=%h", s, o.seg, e.seg); end
         total++; if (o.an !== e.an) begin bad++; $display("FAIL blank_an slot%0d got=%b want=%b", s, o.an, e.an); end
         total++; if (o.dp !== e.dp) begin bad++; $display("FAIL blank_dp slot%0d got=%b want=%b", s, o.dp, e.dp); end
         total++; if (!o.clean) begin bad++; $display("FAIL blank_clean slot%0d got=0 want=1", s); end
         $display("test_blank_dash: slot%0d seg=%h", s, o.seg);
      end
   endtask

   task automatic test_snapshot();
      exp_t e; obs_t o;
      drive_frame(24'h095956, 1'b0, 1'b1);
      @(negedge clk);
      fork
         capture_frame();
         begin
            int w;
            w = 0;
            while (frame_start !== 1'b1 && w < 200) begin
               @(negedge clk);
               w++;
            end
            repeat (2*SD + 4) @(negedge clk);
            drive_frame(24'h095959, 1'b0, 1'b1);
         end
      join
      capture_frame();
      for (int s = 0; s < 12; s++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o.seg !== e.seg) begin bad++; $display("FAIL snap_seg f%0d slot%0d got=%h want=%h", s/6, s%6, o.seg, e.seg); end
         total++; if (o.an !== e.an) begin bad++; $display("FAIL snap_an f%0d slot%0d got=%b want=%b", s/6, s%6, o.an, e.an); end
         total++; if (!o.clean) begin bad++; $display("FAIL snap_clean f%0d slot%0d got=0 want=1", s/6, s%6); end
         $display("test_snapshot: frame%0d slot%0d seg=%h", s/6, s%6, o.seg);
      end
   endtask

   task automatic test_pm();
      exp_t e; obs_t o;
      for (int f = 0; f < 2; f++) begin
         drive_frame(24'h123457, (f == 0), 1'b0);
         @(negedge clk);
         capture_frame();
         for (int s = 0; s < 6; s++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o.dp !== e.dp) begin bad++; $display("FAIL pm_dp pm=%0d slot%0d got=%b want=%b", f == 0, s, o.dp, e.dp); end
            total++; if (o.seg !== e.seg) begin bad++; $display("FAIL pm_seg pm=%0d slot%0d got=%h want=%h", f == 0, s, o.seg, e.seg); end
            $display("test_pm: pm=%0d slot%0d dp=%b", f == 0, s, o.dp);
         end
      end
   endtask

   task automatic test_lzb();
      exp_t e; obs_t o;
      drive_frame(24'h091530, 1'b0, 1'b0);
      @(negedge clk);
      capture_frame();
      for (int s = 0; s < 6; s++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++; if (o.seg !== e.seg) begin bad++; $display("FAIL lzb_seg slot%0d got=%h want=%h", s, o.seg, e.seg); end
         total++; if (o.an !== e.an) begin bad++; $display("FAIL lzb_an slot%0d got=%b want=%b", s, o.an, e.an); end
         total++; if (o.dp !== e.dp) begin bad++; $display("FAIL lzb_dp slot%0d got=%b want=%b", s, o.dp, e.dp); end
         $display("test_lzb: slot%0d seg=%h", s, o.seg);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_reset_async();
      test_blank_dash();
      test_snapshot();
      test_pm();
      test_lzb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
